// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Hazard detection beside the ID stage. Tracks in-flight register writers
//   in shadow EX/MEM/WB slots and returns same-cycle stall/bubble/flush
//   decisions plus registered EX operand forward selects.
// Ports
//   clk, reset             clock, async active-high reset
//   id_*                   decoded operand/destination info of the ID instr
//   ex_branch_taken        branch in EX resolved taken
//   mem_stall              data memory busy, freeze everything
//   stall_o/bubble_o/flush_o  combinational pipeline control
//   fwd_a_sel/fwd_b_sel    EX operand source: 0 regfile, 1 EX/M, 2 M/WB
//   stall_count/flush_count   saturating event counters
module hazard_stall_unit #(
  parameter int REG_ADDR_W         = 5,
  parameter int CNT_W              = 16,
  parameter int ZERO_REG_HARDWIRED = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic                  id_rs_used,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  id_rt_used,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_wr_addr,
  input  logic                  id_is_load,
  input  logic                  ex_branch_taken,
  input  logic                  mem_stall,
  output logic                  stall_o,
  output logic                  bubble_o,
  output logic                  flush_o,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic                  is_load;
  } slot_t;

  slot_t ex_slot, mem_slot, wb_slot;

  function automatic logic hit(input logic used, input logic [REG_ADDR_W-1:0] addr,
                               input logic writes, input logic [REG_ADDR_W-1:0] wr_addr);
    hit = used && writes && (wr_addr == addr) &&
          !((ZERO_REG_HARDWIRED != 0) && (addr == '0));
  endfunction

  logic a_ex, a_mem, b_ex, b_mem, load_use, kill;
  logic [1:0] fwd_a_nxt, fwd_b_nxt;

  assign a_ex  = hit(id_rs_used, id_rs_addr, ex_slot.valid  && ex_slot.wr_en,  ex_slot.wr_addr);
  assign a_mem = hit(id_rs_used, id_rs_addr, mem_slot.valid && mem_slot.wr_en, mem_slot.wr_addr);
  assign b_ex  = hit(id_rt_used, id_rt_addr, ex_slot.valid  && ex_slot.wr_en,  ex_slot.wr_addr);
  assign b_mem = hit(id_rt_used, id_rt_addr, mem_slot.valid && mem_slot.wr_en, mem_slot.wr_addr);

  assign load_use = id_valid && ex_slot.is_load && (a_ex || b_ex);
  // Either a flush or a load-use turns the next EX occupant into a bubble.
  assign kill     = ex_branch_taken || load_use;

  // WB writers are covered by the write-before-read regfile, so the WB slot
  // only keeps the shadow pipe complete and is not consulted for forwarding.
  logic wb_unused;
  assign wb_unused = ^wb_slot;

  always_comb begin
    stall_o  = 1'b0;
    bubble_o = 1'b0;
    flush_o  = 1'b0;
    if (mem_stall) begin
      // A taken branch stays in EX during the freeze and re-asserts after.
      stall_o = 1'b1;
    end else if (ex_branch_taken) begin
      flush_o = 1'b1;
    end else if (load_use) begin
      stall_o  = 1'b1;
      bubble_o = 1'b1;
    end
  end

  // EX match beats MEM match: the EX writer is the youngest producer.
  // A load in EX cannot forward; that case is the load-use stall above.
  always_comb begin
    fwd_a_nxt = 2'd0;
    fwd_b_nxt = 2'd0;
    if (!kill) begin
      if (a_ex && !ex_slot.is_load) fwd_a_nxt = 2'd1;
      else if (a_mem)               fwd_a_nxt = 2'd2;
      if (b_ex && !ex_slot.is_load) fwd_b_nxt = 2'd1;
      else if (b_mem)               fwd_b_nxt = 2'd2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_slot     <= '0;
      mem_slot    <= '0;
      wb_slot     <= '0;
      fwd_a_sel   <= 2'd0;
      fwd_b_sel   <= 2'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else if (!mem_stall) begin
      mem_slot  <= ex_slot;
      wb_slot   <= mem_slot;
      fwd_a_sel <= fwd_a_nxt;
      fwd_b_sel <= fwd_b_nxt;
      if (kill) ex_slot <= '0;
      else      ex_slot <= '{valid: id_valid, wr_en: id_wr_en, wr_addr: id_wr_addr,
                             is_load: id_is_load};
      if (ex_branch_taken) begin
        if (flush_count != '1) flush_count <= flush_count + CNT_W'(1);
      end else if (load_use) begin
        if (stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit
//   Drives one instruction per cycle into hazard_stall_unit (CNT_W=2) and
//   checks it against a small reference model through a scoreboard queue:
//   combinational decisions are compared mid-cycle, registered forward
//   selects and counters just after the following edge.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load;
  logic [4:0] id_rs_addr, id_rt_addr, id_wr_addr;
  logic       ex_branch_taken, mem_stall;
  logic       stall_o, bubble_o, flush_o;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [1:0] stall_count, flush_count;

  hazard_stall_unit #(.REG_ADDR_W(5), .CNT_W(2), .ZERO_REG_HARDWIRED(1)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
    .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: index 0 = EX, 1 = MEM, 2 = WB.
  logic       mv[3], mwe[3], ml[3];
  logic [4:0] ma[3];
  logic [1:0] mfa, mfb;
  int         msc, mfc;

  typedef struct {
    logic       st, bu, fl;
    logic [1:0] fa, fb;
    int         sc, fc;
  } exp_t;
  exp_t sb[$];

  function automatic logic mhit(input logic used, input logic [4:0] a, input int k);
    return used && mv[k] && mwe[k] && (ma[k] == a) && (a != 5'd0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 1'b0; mwe[k] = 1'b0; ml[k] = 1'b0; ma[k] = 5'd0;
    end
    mfa = 2'd0; mfb = 2'd0; msc = 0; mfc = 0;
  endtask

  // Called just after a posedge; returns just after the next posedge.
  task automatic cycle(input logic v, input logic [4:0] rs, input logic ru,
                       input logic [4:0] rt, input logic tu, input logic we,
                       input logic [4:0] wa, input logic ld, input logic br,
                       input logic ms);
    exp_t e;
    logic lu, ah, bh;
    logic [1:0] na, nb;
    id_valid = v; id_rs_addr = rs; id_rs_used = ru; id_rt_addr = rt; id_rt_used = tu;
    id_wr_en = we; id_wr_addr = wa; id_is_load = ld; ex_branch_taken = br; mem_stall = ms;
    ah = mhit(ru, rs, 0);
    bh = mhit(tu, rt, 0);
    lu = v && ml[0] && (ah || bh);
    e.st = ms || (!br && lu);
    e.bu = !ms && !br && lu;
    e.fl = !ms && br;
    if (!ms) begin
      na = (ah && !ml[0]) ? 2'd1 : mhit(ru, rs, 1) ? 2'd2 : 2'd0;
      nb = (bh && !ml[0]) ? 2'd1 : mhit(tu, rt, 1) ? 2'd2 : 2'd0;
      if (br || lu) begin na = 2'd0; nb = 2'd0; end
      if (br) begin if (mfc < 3) mfc++; end
      else if (lu) begin if (msc < 3) msc++; end
      for (int k = 2; k > 0; k--) begin
        mv[k] = mv[k-1]; mwe[k] = mwe[k-1]; ma[k] = ma[k-1]; ml[k] = ml[k-1];
      end
      mv[0] = v && !(br || lu); mwe[0] = we; ma[0] = wa; ml[0] = ld;
      mfa = na; mfb = nb;
    end
    e.fa = mfa; e.fb = mfb; e.sc = msc; e.fc = mfc;
    sb.push_back(e);
    @(negedge clk);
    chk("stall_o", stall_o, sb[0].st);
    chk("bubble_o", bubble_o, sb[0].bu);
    chk("flush_o", flush_o, sb[0].fl);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("fwd_a_sel", fwd_a_sel, e.fa);
    chk("fwd_b_sel", fwd_b_sel, e.fb);
    chk("stall_count", stall_count, e.sc);
    chk("flush_count", flush_count, e.fc);
  endtask

  task automatic ins(input logic [4:0] rs, input logic ru, input logic [4:0] rt,
                     input logic tu, input logic we, input logic [4:0] wa, input logic ld);
    cycle(1'b1, rs, ru, rt, tu, we, wa, ld, 1'b0, 1'b0);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    id_valid = 0; id_rs_addr = 0; id_rs_used = 0; id_rt_addr = 0; id_rt_used = 0;
    id_wr_en = 0; id_wr_addr = 0; id_is_load = 0; ex_branch_taken = 0; mem_stall = 0;
    model_reset();
    #3;
    chk("rst_stall", stall_o, 0);
    chk("rst_bubble", bubble_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_fwd_a", fwd_a_sel, 0);
    chk("rst_fwd_b", fwd_b_sel, 0);
    chk("rst_stall_cnt", stall_count, 0);
    chk("rst_flush_cnt", flush_count, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // EX forward: write r3, then read r3 as rs
    ins(5'd0, 0, 5'd0, 0, 1, 5'd3, 0);
    ins(5'd3, 1, 5'd0, 0, 0, 5'd0, 0);
    chk("t1_fwd_a", fwd_a_sel, 1);
    nop(3);

    // Load-use: load r5, read r5 as rt (stall), retry gets M/WB forward
    ins(5'd0, 0, 5'd0, 0, 1, 5'd5, 1);
    ins(5'd0, 0, 5'd5, 1, 0, 5'd0, 0);
    ins(5'd0, 0, 5'd5, 1, 0, 5'd0, 0);
    chk("t2_fwd_b", fwd_b_sel, 2);
    chk("t2_stall_cnt", stall_count, 1);
    nop(3);

    // Double producer: youngest wins; r0 never hazards
    ins(5'd0, 0, 5'd0, 0, 1, 5'd7, 0);
    ins(5'd0, 0, 5'd0, 0, 1, 5'd7, 0);
    ins(5'd7, 1, 5'd0, 0, 0, 5'd0, 0);
    chk("t3_fwd_a", fwd_a_sel, 1);
    ins(5'd0, 0, 5'd0, 0, 1, 5'd0, 1);
    ins(5'd0, 0, 5'd0, 0, 1, 5'd0, 0);
    ins(5'd0, 1, 5'd0, 1, 0, 5'd0, 0);
    chk("t3_r0_fwd_a", fwd_a_sel, 0);
    nop(3);

    // Branch beats load-use; next EX slot empty so the retry sees MEM
    ins(5'd0, 0, 5'd0, 0, 1, 5'd9, 1);
    cycle(1, 5'd0, 0, 5'd9, 1, 0, 5'd0, 0, 1, 0);
    chk("t4_flush_cnt", flush_count, 1);
    chk("t4_stall_cnt", stall_count, 1);
    ins(5'd0, 0, 5'd9, 1, 0, 5'd0, 0);
    chk("t4_fwd_b", fwd_b_sel, 2);
    nop(3);

    // Freeze with pending load-use and taken branch, then flush resolves
    ins(5'd0, 0, 5'd0, 0, 1, 5'd10, 1);
    for (int i = 0; i < 3; i++) cycle(1, 5'd10, 1, 5'd0, 0, 0, 5'd0, 0, 1, 1);
    chk("t5_frz_flush_cnt", flush_count, 1);
    cycle(1, 5'd10, 1, 5'd0, 0, 0, 5'd0, 0, 1, 0);
    chk("t5_flush_cnt", flush_count, 2);
    ins(5'd10, 1, 5'd0, 0, 0, 5'd0, 0);
    chk("t5_fwd_a", fwd_a_sel, 2);
    nop(3);

    // Saturation: five more load-use stalls on a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      ins(5'd0, 0, 5'd0, 0, 1, 5'(11 + i), 1);
      ins(5'(11 + i), 1, 5'd0, 0, 0, 5'd0, 0);
      ins(5'(11 + i), 1, 5'd0, 0, 0, 5'd0, 0);
    end
    chk("t6_stall_sat", stall_count, 3);

    // Async reset in the middle of a load-use stall
    ins(5'd0, 0, 5'd0, 0, 1, 5'd20, 1);
    id_valid = 1; id_rs_addr = 5'd20; id_rs_used = 1; id_rt_used = 0;
    id_wr_en = 0; id_is_load = 0; ex_branch_taken = 0; mem_stall = 0;
    #1;
    chk("t6_pre_stall", stall_o, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_stall", stall_o, 0);
    chk("t6_rst_bubble", bubble_o, 0);
    chk("t6_rst_flush", flush_o, 0);
    chk("t6_rst_fwd_a", fwd_a_sel, 0);
    chk("t6_rst_stall_cnt", stall_count, 0);
    chk("t6_rst_flush_cnt", flush_count, 0);
    model_reset();
    id_valid = 0; id_rs_used = 0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    ins(5'd0, 0, 5'd0, 0, 1, 5'd3, 0);
    ins(5'd0, 0, 5'd3, 1, 0, 5'd0, 0);
    chk("post_rst_fwd_b", fwd_b_sel, 1);
    nop(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Backward-flowing companion to the forward control pipeline: tracks in-flight register writers in EX, MEM and WB and returns stall, bubble, flush and forwarding decisions to the fetch and decode stages.
- Sits beside the ID stage. It takes decoded operand and destination info plus EX/MEM status, and drives the pipeline-register enables and EX operand muxes.
- Keeps its own shadow copy of writer info per stage, plus saturating stall and flush event counters.

Parameters:
- REG_ADDR_W, 5, register address width.
- CNT_W, 16, width of the performance counters.
- ZERO_REG_HARDWIRED, 1, when 1, address 0 never creates a hazard or a forward.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous active-high reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs_addr  in  REG_ADDR_W  source A address.
- id_rs_used  in  1  source A is read.
- id_rt_addr  in  REG_ADDR_W  source B address.
- id_rt_used  in  1  source B is read.
- id_wr_en  in  1  the instruction writes a register.
- id_wr_addr  in  REG_ADDR_W  destination address.
- id_is_load  in  1  the instruction is a load.
- ex_branch_taken  in  1  the branch in EX resolved taken.
- mem_stall  in  1  data memory busy; freeze the whole pipe.
- stall_o  out  1  hold the PC and IF/ID register (combinational).
- bubble_o  out  1  load NOP into ID/EX (combinational).
- flush_o  out  1  kill the IF/ID and ID/EX contents (combinational).
- fwd_a_sel  out  2  EX operand A source, registered: 0 = regfile, 1 = EX/M, 2 = M/WB.
- fwd_b_sel  out  2  EX operand B source, same encoding.
- stall_count  out  CNT_W  load-use stall cycles, saturating.
- flush_count  out  CNT_W  flush events, saturating.

Behaviour:
- State is three shadow slots: ex, mem and wb. Each slot holds {valid, wr_en, wr_addr, is_load}.
- A source "matches" a slot when all of these hold:
  - the source is used;
  - the slot is valid and has wr_en set;
  - the addresses are equal;
  - the address is not 0 when ZERO_REG_HARDWIRED=1.
- Priority per cycle, evaluated combinationally:
  1. **mem_stall=1:** stall_o=1; bubble_o=0 and flush_o=0, even if a branch is taken, because the branch stays in EX and re-asserts. Slots, fwd selects and counters hold.
  2. **ex_branch_taken=1:** flush_o=1; stall_o=0 and bubble_o=0, so a flush overrides a simultaneous load-use. On the next edge: ex slot loads invalid, mem takes the old ex, wb takes the old mem, fwd selects load 0, and flush_count increments.
  3. **Load-use** (id_valid, and either source matches the ex slot with is_load=1): stall_o=1 and bubble_o=1. On the next edge: ex loads invalid, the other slots shift, fwd selects load 0, and stall_count increments. On the following cycle the load is in mem, so the retried instruction gets sel=2.
  4. **Otherwise:** all three outputs are 0. On the next edge, ex loads the ID info (valid=id_valid) and mem/wb shift.
- Forward select loaded on an advancing edge, per source:
  - 1 if the source matches the current ex slot (non-load);
  - else 2 if it matches the current mem slot;
  - else 0.
- A WB-stage writer needs no forward: the regfile is write-before-read.
- When both ex and mem match, the ex slot wins (sel=1), because it is the youngest producer.
- The fwd selects are valid during the cycle the instruction occupies EX.
- Latency: the hazard decision is same-cycle; forward selects are available one cycle after decode.
- Counters stop at all-ones and do not wrap. Freeze cycles are not counted.
- Reset, asynchronous, effective immediately mid-operation:
  - all slots invalid;
  - fwd_a_sel and fwd_b_sel = 0;
  - both counters = 0;
  - the combinational outputs become 0 because no slot is valid (mem_stall and branch excluded).

Test Plan:
1. **EX forward:** write r3, then next cycle read r3 as rs -> stall_o=0; fwd_a_sel=1 during the consumer's EX cycle.
2. **Load-use:** load r5, then next cycle read r5 as rt -> one cycle with stall_o=1 and bubble_o=1, then fwd_b_sel=2; stall_count=1.
3. **Double producer:** write r7, write r7, then read r7 -> fwd_a_sel=1 (youngest wins). Repeat with r0 -> sel stays 0 and no stall.
4. **Branch vs load-use:** ex_branch_taken=1 in the same cycle as a load-use match -> flush_o=1, stall_o=0, flush_count=1, stall_count unchanged, and the next ex slot is invalid.
5. **Freeze:** mem_stall=1 for 3 cycles with a pending load-use and a taken branch -> stall_o=1, flush_o=0, and slots and counters unchanged. After release, the flush resolves first.
6. **Saturation and reset:** with CNT_W=2, trigger 5 load-use stalls -> stall_count=3. Then assert reset mid-stall -> all outputs 0 asynchronously, before the next clk edge.
